shift_register_sequencer: RTL and testbench
===========================================

Name: shift_register_sequencer

Overview:
- Sequences one ShiftRegister instance (WIDTH-bit, controls enable/shiftEnable/dataIn, result dataOut) on behalf of a single requester.
- Accepts a job (word + shift count) over a valid/ready handshake, parallel-loads the word, issues the requested number of single-step shifts, then returns the shifted word over a second valid/ready handshake.
- Sits between the requester and the ShiftRegister; it is the only driver of the ShiftRegister's control inputs.

Parameters:
- WIDTH, 6, data width; equals the ShiftRegister width.
- CNT_W, 3, width of in_count; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  job offered
- in_ready  output  1  sequencer can accept a job
- in_data  input  WIDTH  word to load
- in_count  input  CNT_W  number of single-step shifts requested
- out_valid  output  1  result available
- out_ready  input  1  requester takes result
- out_data  output  WIDTH  shifted word; 0 when out_valid=0
- busy  output  1  job in progress (state != IDLE)
- sr_enable  output  1  to ShiftRegister enable
- sr_shift_enable  output  1  to ShiftRegister shiftEnable
- sr_data_in  output  WIDTH  to ShiftRegister dataIn
- sr_data_out  input  WIDTH  from ShiftRegister dataOut

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Reset is sampled only on rising clk edges.
- ShiftRegister control contract, sampled at the next rising edge:
  - enable=1, shiftEnable=0: parallel load of dataIn.
  - enable=1, shiftEnable=1: one shift step.
  - enable=0: hold.
- FSM states are IDLE, LOAD, SHIFT, DONE. All outputs are decoded from registered state and registers only (Moore).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, sr_enable=0, sr_shift_enable=0, sr_data_in=0, remaining count=0, latched word=0.
- IDLE:
  - in_ready=1; sr_enable=0.
  - On in_valid, latch in_data and the clamped count (in_count > WIDTH is clamped to WIDTH), then go to LOAD.
- LOAD:
  - Lasts one cycle; sr_enable=1, sr_shift_enable=0, sr_data_in=latched word.
  - Next state is SHIFT if count>0, otherwise DONE.
- SHIFT:
  - sr_enable=1, sr_shift_enable=1 every cycle; remaining count decrements each cycle.
  - Go to DONE in the cycle remaining==1. Exactly count shift pulses are issued.
- DONE:
  - sr_enable=0, so the ShiftRegister holds; out_valid=1, out_data=sr_data_out.
  - Stay in DONE until out_ready=1, then go to IDLE.
- Handshakes:
  - A transfer occurs when valid and ready are both 1 on a rising edge.
  - in_ready=0 in LOAD, SHIFT and DONE; requests there are ignored, not queued.
  - in_valid may be held across busy cycles without effect.
- Latency: accept edge to first out_valid cycle = clamped count + 1 cycles (LOAD + count SHIFT cycles). With out_ready held at 1, throughput is one job per count+3 cycles.
- out_ready asserted outside DONE has no effect.
- When out_valid and out_ready are in the same cycle as a new in_valid, the new job is not accepted that cycle. It is accepted in the following IDLE cycle.
- Reset mid-job (any state): return to IDLE next edge and drop the job.
  - All outputs take their reset values, and no further sr_enable pulse is issued.
  - The ShiftRegister's own reset is driven by the same reset.
- sr_data_in is held at the latched word through SHIFT and DONE. It is 0 only after reset, until the first job is accepted.

Decomposition:
- Shared package shift_seq_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_LOAD=2'd1, ST_SHIFT=2'd2, ST_DONE=2'd3;
  - the WIDTH and CNT_W defaults.
- No sub-module; the FSM, count register and word latch live in one module.
- A top-level wrapper instantiating shift_register_sequencer plus ShiftRegister is built separately for the bench.

Test Plan:
- Bench model for the ShiftRegister: shift left, zero fill.
- Reset: hold reset=1 for 2 cycles -> in_ready=1, out_valid=0, sr_enable=0, busy=0, out_data=0.
- Basic job: in_data=49 (110001), in_count=2, out_ready=1 -> one LOAD cycle and exactly 2 shift-pulse cycles; out_valid asserted 3 cycles after accept; out_data=4 (000100).
- Zero count: in_data=49, in_count=0 -> LOAD, then DONE next cycle; out_data=49; no sr_shift_enable pulse.
- Clamp: in_data=63, in_count=7 -> exactly 6 shift pulses; out_data=0; out_valid 7 cycles after accept.
- Back-pressure and busy: out_ready=0 for 5 cycles in DONE, with in_valid=1 held throughout -> out_valid and out_data stable, in_ready=0, no new job. Then out_ready=1 -> IDLE; new job accepted on the next edge.
- Reset mid-SHIFT: assert reset during the second shift cycle of an in_count=5 job -> next cycle state IDLE, sr_enable=0, out_valid=0; no result emitted.

Source files
------------

// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_pkg
// Purpose  : Shared definitions for the shift-register sequencer: default
//            data/count widths and the FSM state encoding.
// Revision : 1.0  initial release
// ============================================================================
package shift_seq_pkg;

  // Default data width (matches the attached ShiftRegister) and count width.
  // The count width must be able to represent WIDTH itself.
  localparam int SSQ_WIDTH = 6;
  localparam int SSQ_CNT_W = 3;

  // State encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_register_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_sequencer
// Purpose  : Drives a single ShiftRegister on behalf of one requester.
//            A job (word + shift count) is accepted over a valid/ready
//            handshake, the word is parallel-loaded, the requested number of
//            single-step shifts is issued, and the shifted word is returned
//            over a second valid/ready handshake.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            in_valid/in_ready     - job handshake
//            in_data, in_count     - word to load, number of shift steps
//            out_valid/out_ready   - result handshake
//            out_data              - shifted word (0 while out_valid=0)
//            busy                  - a job is in progress
//            sr_enable, sr_shift_enable, sr_data_in - ShiftRegister controls
//            sr_data_out           - ShiftRegister contents
// Revision : 1.0  initial release
// ============================================================================
module shift_register_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = SSQ_WIDTH,
  parameter int CNT_W = SSQ_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             sr_enable,
  output logic             sr_shift_enable,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_data_out
);

  // Largest meaningful shift count: beyond WIDTH steps the word is all zero.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic [CNT_W-1:0] count_clamped;

  assign count_clamped = (in_count > CNT_MAX) ? CNT_MAX : in_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          count_d = count_clamped;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = (count_q == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        // count_q holds the pulses still to issue including this cycle's.
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from the state register and latched word only.
  // out_data passes the ShiftRegister contents straight through in DONE,
  // where the register is held because sr_enable is low.
  assign in_ready        = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign sr_enable       = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign sr_shift_enable = (state_q == S_SHIFT);
  assign sr_data_in      = word_q;
  assign out_valid       = (state_q == S_DONE);
  assign out_data        = (state_q == S_DONE) ? sr_data_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_register_sequencer
// Purpose  : Self-checking bench for shift_register_sequencer. A behavioural
//            ShiftRegister (shift left, zero fill) is attached; each job's
//            expected result, latency and pulse count come from plain
//            arithmetic on the job parameters.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_register_sequencer;

  localparam int W  = 6;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic          sr_enable;
  logic          sr_shift_enable;
  logic [W-1:0]  sr_data_in;
  logic [W-1:0]  sr_q;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_register_sequencer #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_count        (in_count),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .busy            (busy),
    .sr_enable       (sr_enable),
    .sr_shift_enable (sr_shift_enable),
    .sr_data_in      (sr_data_in),
    .sr_data_out     (sr_q)
  );

  // Behavioural ShiftRegister: load / shift-left-zero-fill / hold.
  always_ff @(posedge clk) begin
    if (reset)                sr_q <= '0;
    else if (sr_enable) begin
      if (sr_shift_enable)    sr_q <= {sr_q[W-2:0], 1'b0};
      else                    sr_q <= sr_data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One complete job. delay = cycles of back-pressure in DONE; hold keeps
  // in_valid asserted (with changing data) for the whole job.
  task automatic run_job(input int d, input int c, input int delay, input bit hold);
    int clamp;
    int exp;
    int n;
    int pulses;
    clamp = (c > W) ? W : c;
    exp   = (d << clamp) & ((1 << W) - 1);

    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = W'(d);
    in_count = CW'(c);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;

    check("load_ctrl", {sr_enable, sr_shift_enable}, 2'b10);
    check("load_word", sr_data_in, d);
    check("load_busy", {busy, in_ready}, 2'b10);

    n = 0;
    pulses = 0;
    while (!out_valid && n < 20) begin
      if (sr_enable && sr_shift_enable) pulses++;
      in_data   = W'($urandom);
      in_count  = CW'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    check("latency", n, clamp + 1);
    check("pulses", pulses, clamp);
    if (!out_valid) return;

    check("result", out_data, exp);
    check("done_hold", {sr_enable, in_ready, busy}, 3'b001);

    for (int i = 0; i < delay; i++) begin
      out_ready = 1'b0;
      in_data   = W'($urandom);
      in_count  = CW'($urandom);
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, exp);
      check("bp_in_ready", in_ready, 0);
      check("bp_word", sr_data_in, d);
    end

    out_ready = 1'b1;
    @(negedge clk);
    check("ret_idle", {in_ready, busy, out_valid}, 3'b100);
    check("ret_data", out_data, 0);
    out_ready = 1'b0;
  endtask

  task automatic reset_mid_shift();
    in_valid = 1'b1;
    in_data  = W'($urandom);
    in_count = CW'(5);
    @(negedge clk);               // LOAD
    in_valid = 1'b0;
    @(negedge clk);               // first SHIFT
    @(negedge clk);               // second SHIFT
    check("rst_pre_shift", {sr_enable, sr_shift_enable}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_state", {in_ready, busy, out_valid, sr_enable}, 4'b1000);
    check("rst_out_data", out_data, 0);
    check("rst_word", sr_data_in, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_quiet", {sr_enable, out_valid, busy}, 3'b000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_count  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {in_ready, out_valid, sr_enable, busy}, 4'b1000);
    check("reset_data", out_data, 0);
    reset = 1'b0;
    @(negedge clk);

    run_job(49, 2, 0, 1'b0);      // 110001 << 2 -> 000100
    run_job(49, 0, 0, 1'b0);      // no shifts
    run_job(63, 7, 0, 1'b0);      // clamped to 6 shifts -> 0
    run_job(49, 2, 5, 1'b1);      // back-pressure with in_valid held
    run_job(22, 3, 0, 1'b0);      // accepted right after the held job

    for (int k = 0; k < 30; k++) begin
      run_job(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    in_valid = 1'b0;
    @(negedge clk);
    reset_mid_shift();
    run_job(45, 1, 1, 1'b0);      // recovery after reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
